serial_adder_seq: RTL and testbench

Multi-cycle controller that reuses one 3-bit ripple adder slice to add two WIDTH-bit operands plus a carry-in. Each RUN cycle it adds one 3-bit chunk, least-significant chunk first, and holds the carry in a register between chunks. It sits between a producer and a consumer on valid/ready handshakes, so the small slice can stand in for a wide adder in area-constrained partitions.

---
 rtl/adder_seq_pkg.sv | 6 +
 rtl/serial_adder_seq_if.sv | 23 ++
 rtl/adder_slice3.sv | 17 +
 rtl/serial_adder_seq.sv | 98 +++++++++
 tb/tb_serial_adder_seq.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared FSM state type and slice width for the serial adder
// Contents: state_t (IDLE, RUN, DONE), SLICE_W (bits added per pass)
package adder_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SLICE_W = 3;
endpackage

// File: rtl/serial_adder_seq_if.sv
// serial_adder_seq_if: operand/result valid-ready bundle for serial_adder_seq
// Ports: in_valid/in_ready/a/b/cin (operation in), out_valid/out_ready/sum/cout (result out), busy
// Modports: master = producer/consumer side, slave = adder side
interface serial_adder_seq_if #(parameter int WIDTH = 12);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/adder_slice3.sv
// adder_slice3: combinational 3-bit ripple-carry slice
// Ports: x, y (3-bit addends), ci (carry in), s (3-bit sum), co (carry out)
module adder_slice3 (
    input  logic [2:0] x,
    input  logic [2:0] y,
    input  logic       ci,
    output logic [2:0] s,
    output logic       co
);
    logic [3:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < 3; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    assign co = c[3];
endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: adds two WIDTH-bit operands plus carry-in one 3-bit chunk per cycle
// Ports: clk, rst_n (sync, active low), bus (slave side of serial_adder_seq_if)
// Flow: IDLE accepts an operation, RUN makes NCHUNK slice passes LSB first, DONE holds the result
module serial_adder_seq
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / SLICE_W;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (WIDTH <= 0 || WIDTH % SLICE_W != 0) begin : g_bad_width
        $error("serial_adder_seq: WIDTH must be a positive multiple of 3");
    end

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;
    logic             busy_reg;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    adder_slice3 u_slice (
        .x  (a_reg[int'(idx)*SLICE_W +: SLICE_W]),
        .y  (b_reg[int'(idx)*SLICE_W +: SLICE_W]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // in_ready is registered so it stays low for the whole reset and rises one edge after release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (bus.in_valid && in_ready_reg) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        carry        <= bus.cin;
                        idx          <= '0;
                        sum_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[int'(idx)*SLICE_W +: SLICE_W] <= slice_s;
                    carry <= slice_co;
                    idx   <= (idx == LAST) ? idx : idx + 1'b1;
                    if (idx == LAST) begin
                        cout_reg      <= slice_co;
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: randomized self-checking bench for serial_adder_seq (WIDTH=12 and WIDTH=3)
module tb_serial_adder_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    serial_adder_seq_if #(.WIDTH(12)) bus12 ();
    serial_adder_seq_if #(.WIDTH(3))  bus3 ();

    serial_adder_seq #(.WIDTH(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus12));
    serial_adder_seq #(.WIDTH(3))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // drives one operation into the 12-bit DUT and returns edges from accept to out_valid
    task automatic do_accept(input logic [11:0] a, input logic [11:0] b, input logic c, output int lat);
        bus12.a = a;
        bus12.b = b;
        bus12.cin = c;
        bus12.in_valid = 1'b1;
        for (int i = 0; i < 20 && !bus12.in_ready; i++) step();
        n_checks++;
        if (bus12.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", bus12.in_ready);
        end
        step();
        bus12.in_valid = 1'b0;
        bus12.a = 12'($urandom);
        bus12.b = 12'($urandom);
        bus12.cin = 1'($urandom);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus12.out_valid && lat < 20);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus12.in_ready, bus12.out_valid, bus12.busy, bus12.cout, bus12.sum} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/vld/busy/cout/sum=%h required 0",
                     {bus12.in_ready, bus12.out_valid, bus12.busy, bus12.cout, bus12.sum});
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus12.in_ready !== 1'b1 || bus3.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b/%b required 1/1", bus12.in_ready, bus3.in_ready);
        end
    endtask

    task automatic test_ripple;
        int lat;
        do_accept(12'hFFF, 12'h001, 1'b0, lat);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL ripple_latency: got %0d required 4", lat);
        end
        n_checks++;
        if ({bus12.cout, bus12.sum} !== 13'h1000 || bus12.busy !== 1'b1 || bus12.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_result: cout/sum=%h busy=%b in_ready=%b required 1000 1 0",
                     {bus12.cout, bus12.sum}, bus12.busy, bus12.in_ready);
        end
        bus12.out_ready = 1'b1;
        step();
        bus12.out_ready = 1'b0;
        n_checks++;
        if (bus12.out_valid !== 1'b0 || bus12.in_ready !== 1'b1 || bus12.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_handshake: vld=%b rdy=%b busy=%b required 0 1 0",
                     bus12.out_valid, bus12.in_ready, bus12.busy);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        do_accept(12'h5A3, 12'h2C4, 1'b1, lat);
        n_checks++;
        if (lat !== 4 || {bus12.cout, bus12.sum} !== 13'h0868) begin
            n_fail++;
            $display("FAIL bp_result: lat=%0d cout/sum=%h required 4 0868", lat, {bus12.cout, bus12.sum});
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus12.out_valid !== 1'b1 || {bus12.cout, bus12.sum} !== 13'h0868 || bus12.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d vld=%b cout/sum=%h rdy=%b required 1 0868 0",
                         i, bus12.out_valid, {bus12.cout, bus12.sum}, bus12.in_ready);
            end
        end
        bus12.out_ready = 1'b1;
        step();
        bus12.out_ready = 1'b0;
        n_checks++;
        if (bus12.out_valid !== 1'b0 || bus12.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b required 0 1", bus12.out_valid, bus12.in_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] got[$];
        int acc = 0;
        int t0 = 0;
        int t1 = 0;
        bus12.out_ready = 1'b1;
        bus12.a = 12'h123;
        bus12.b = 12'h456;
        bus12.cin = 1'b0;
        bus12.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus12.out_valid) got.push_back({bus12.cout, bus12.sum});
            if (bus12.in_valid && bus12.in_ready) begin
                acc++;
                if (acc == 1) t0 = i;
                else t1 = i;
            end
            step();
            if (acc == 1) begin
                bus12.a = 12'h001;
                bus12.b = 12'h001;
            end
            if (acc >= 2) bus12.in_valid = 1'b0;
        end
        bus12.out_ready = 1'b0;
        bus12.in_valid = 1'b0;
        n_checks++;
        if (acc !== 2 || t1 - t0 !== 6) begin
            n_fail++;
            $display("FAIL b2b_accepts: count=%0d gap=%0d required 2 6", acc, t1 - t0);
        end
        n_checks++;
        if (got.size() !== 2 || got[0] !== 13'h0579 || got[1] !== 13'h0002) begin
            n_fail++;
            $display("FAIL b2b_results: n=%0d first=%h second=%h required 2 0579 0002",
                     got.size(), got.size() > 0 ? got[0] : 13'h0, got.size() > 1 ? got[1] : 13'h0);
        end
    endtask

    task automatic test_reset_mid_run;
        bool_dummy: begin end
        bus12.a = 12'hABC;
        bus12.b = 12'h777;
        bus12.cin = 1'b1;
        bus12.in_valid = 1'b1;
        step();
        bus12.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if ({bus12.in_ready, bus12.out_valid, bus12.busy, bus12.cout, bus12.sum} !== 16'h0) begin
            n_fail++;
            $display("FAIL midrun_reset: rdy/vld/busy/cout/sum=%h required 0",
                     {bus12.in_ready, bus12.out_valid, bus12.busy, bus12.cout, bus12.sum});
        end
        step();
        n_checks++;
        if (bus12.in_ready !== 1'b1 || bus12.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_release: rdy=%b vld=%b required 1 0", bus12.in_ready, bus12.out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (bus12.out_valid !== 1'b0 || bus12.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_stale: cycle %0d vld=%b busy=%b required 0 0", i, bus12.out_valid, bus12.busy);
            end
        end
    endtask

    task automatic test_random;
        int lat;
        logic [11:0] a, b;
        logic c;
        logic [12:0] exp_res;
        bit taken;
        for (int n = 0; n < 4000; n++) begin
            a = 12'($urandom);
            b = 12'($urandom);
            c = 1'($urandom);
            exp_res = 13'(a) + 13'(b) + 13'(c);
            do_accept(a, b, c, lat);
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL rand_latency: op %0d got %0d required 4", n, lat);
            end
            taken = 1'b0;
            for (int w = 0; w < 30 && !taken; w++) begin
                bus12.out_ready = 1'($urandom);
                if (bus12.out_ready && bus12.out_valid) begin
                    taken = 1'b1;
                    n_checks++;
                    if ({bus12.cout, bus12.sum} !== exp_res) begin
                        n_fail++;
                        $display("FAIL rand_sum: op %0d %h+%h+%b got %h required %h",
                                 n, a, b, c, {bus12.cout, bus12.sum}, exp_res);
                    end
                end
                step();
            end
            bus12.out_ready = 1'b0;
            n_checks++;
            if (!taken || bus12.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_handshake: op %0d taken=%b vld_after=%b required 1 0", n, taken, bus12.out_valid);
            end
        end
    endtask

    task automatic test_width3;
        bus3.a = 3'd7;
        bus3.b = 3'd7;
        bus3.cin = 1'b1;
        bus3.in_valid = 1'b1;
        for (int i = 0; i < 20 && !bus3.in_ready; i++) step();
        step();
        bus3.in_valid = 1'b0;
        step();
        n_checks++;
        if (bus3.out_valid !== 1'b1 || {bus3.cout, bus3.sum} !== 4'hF) begin
            n_fail++;
            $display("FAIL w3_result: vld=%b cout/sum=%h required 1 f", bus3.out_valid, {bus3.cout, bus3.sum});
        end
        bus3.out_ready = 1'b1;
        step();
        bus3.out_ready = 1'b0;
        n_checks++;
        if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL w3_handshake: vld=%b rdy=%b required 0 1", bus3.out_valid, bus3.in_ready);
        end
    endtask

    initial begin
        bus12.in_valid = 1'b0;
        bus12.a = '0;
        bus12.b = '0;
        bus12.cin = 1'b0;
        bus12.out_ready = 1'b0;
        bus3.in_valid = 1'b0;
        bus3.a = '0;
        bus3.b = '0;
        bus3.cin = 1'b0;
        bus3.out_ready = 1'b0;
        test_reset();
        test_ripple();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_width3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
